cpu_ctrl: RTL and testbench

- Instruction-sequencing controller for the 8-bit von Neumann CPU.
- Walks each instruction through fetch, decode, operand access and execute, driving the load enables of the instruction register, program counter and accumulator, and the shared memory bus strobes.
- Sits between the instruction register's opcode field (IR[7:5]) and every datapath enable.
- Adds a memory wait-state handshake with a bus-timeout halt.

---
 rtl/cpu_ctrl.sv | 155 +++++++++++++++
 tb/tb_cpu_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Instruction-sequencing controller for the 8-bit von Neumann CPU.
// Adds memory wait states with a bus-timeout halt.
module cpu_ctrl #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       mem_rdy,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       data_e,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       halt,
   output logic       bus_err,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      FETCH_ADDR = 3'd0,
      FETCH_RD   = 3'd1,
      LOAD_IR    = 3'd2,
      DECODE     = 3'd3,
      OP_RD      = 3'd4,
      EXEC       = 3'd5,
      STORE      = 3'd6,
      HALTED     = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } op_t;

   localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait_cnt;
   logic       r_bus_err;
   logic       w_waiting;
   logic       w_timeout;
   op_t        w_op;

   assign w_op      = op_t'(opcode);
   assign w_waiting = (r_state == FETCH_RD) || (r_state == OP_RD) || (r_state == STORE);
   // mem_rdy in the limit cycle still counts as success
   assign w_timeout = w_waiting && !mem_rdy && (r_wait_cnt == LAST_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= FETCH_ADDR;
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_timeout)
            r_bus_err <= 1'b1;
         if (w_next != r_state)
            r_wait_cnt <= '0;
         else if (w_waiting && !mem_rdy)
            r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH_ADDR: w_next = FETCH_RD;
         FETCH_RD:   if (mem_rdy) w_next = LOAD_IR;
         LOAD_IR:    w_next = DECODE;
         DECODE: begin
            case (w_op)
               OP_HLT:                         w_next = HALTED;
               OP_STO:                         w_next = STORE;
               OP_SKZ, OP_JMP:                 w_next = EXEC;
               default:                        w_next = OP_RD;
            endcase
         end
         OP_RD:      if (mem_rdy) w_next = EXEC;
         EXEC:       w_next = FETCH_ADDR;
         STORE:      if (mem_rdy) w_next = FETCH_ADDR;
         HALTED:     w_next = HALTED;
         default:    w_next = FETCH_ADDR;
      endcase
      if (w_timeout)
         w_next = HALTED;
   end

   // Reset overrides the decode so no strobe fires while rst is held.
   always_comb begin
      sel     = 1'b0;
      rd      = 1'b0;
      wr      = 1'b0;
      data_e  = 1'b0;
      ld_ir   = 1'b0;
      inc_pc  = 1'b0;
      ld_pc   = 1'b0;
      ld_ac   = 1'b0;
      halt    = 1'b0;
      bus_err = 1'b0;
      phase   = FETCH_ADDR;
      if (rst) begin
         sel = 1'b1;
      end else begin
         phase = r_state;
         case (r_state)
            FETCH_ADDR: sel = 1'b1;
            FETCH_RD: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            LOAD_IR: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            DECODE: inc_pc = 1'b1;
            OP_RD:  rd = 1'b1;
            EXEC: begin
               case (w_op)
                  OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                     rd    = 1'b1;
                     ld_ac = 1'b1;
                  end
                  OP_SKZ:  inc_pc = zero;
                  OP_JMP:  ld_pc  = 1'b1;
                  default: ;
               endcase
            end
            STORE: begin
               data_e = 1'b1;
               wr     = 1'b1;
            end
            HALTED: begin
               halt    = 1'b1;
               bus_err = r_bus_err;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed instruction table plus random
// instruction streams, each expanded into expected per-cycle output records.
module tb_cpu_ctrl;

   localparam int LIMIT = 4;

   logic       clk;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       mem_rdy;
   logic       sel, rd, wr, data_e, ld_ir, inc_pc, ld_pc, ld_ac, halt, bus_err;
   logic [2:0] phase;

   cpu_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
      .sel(sel), .rd(rd), .wr(wr), .data_e(data_e), .ld_ir(ld_ir),
      .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .halt(halt),
      .bus_err(bus_err), .phase(phase)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {sel,rd,wr,data_e,ld_ir,inc_pc,ld_pc,ld_ac,halt,bus_err,phase}
   logic [12:0] obs;
   assign obs = {sel, rd, wr, data_e, ld_ir, inc_pc, ld_pc, ld_ac, halt, bus_err, phase};

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        z;
      logic [2:0]  op;
      logic [12:0] exp;
   } cyc_t;

   typedef struct {
      logic [2:0] op;
      logic       z;
      int         wf;
      int         wo;
      int         ws;
      int         cyc;
      int         inc;
      logic       h;
      logic       be;
   } dir_t;

   cyc_t q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc_idx = 0;
   int   obs_cyc, obs_inc;
   logic obs_h, obs_be;

   function automatic logic [12:0] ev(input logic s, r, w, d, li, ip, lp, la, h, be,
                                      input logic [2:0] ph);
      return {s, r, w, d, li, ip, lp, la, h, be, ph};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc_idx, act, expv);
   endtask

   task automatic chk_int(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   task automatic push(input logic rs, input logic rdy, input logic z,
                       input logic [2:0] op, input logic [12:0] e);
      cyc_t c;
      c.rst = rs; c.rdy = rdy; c.z = z; c.op = op; c.exp = e;
      q.push_back(c);
   endtask

   // A memory phase is occupied for w wait cycles plus the ready cycle,
   // but never longer than LIMIT cycles without mem_rdy.
   task automatic access(input logic [2:0] op, input logic [12:0] e, input int w,
                         output bit ok);
      int n;
      n = (w < LIMIT) ? w : LIMIT;
      for (int k = 0; k < n; k++) push(1'b0, 1'b0, rb(), op, e);
      ok = (w < LIMIT);
      if (ok) push(1'b0, 1'b1, rb(), op, e);
   endtask

   task automatic halted(input logic [2:0] op, input logic be, input int dwell);
      for (int k = 0; k < dwell; k++)
         push(1'b0, rb(), rb(), op, ev(0,0,0,0,0,0,0,0,1,be,3'd7));
      push(1'b1, rb(), rb(), op, ev(1,0,0,0,0,0,0,0,0,0,3'd0));
   endtask

   task automatic gen_instr(input logic [2:0] op, input logic z, input int wf,
                            input int wo, input int ws, input int hdwell);
      bit ok;
      push(1'b0, rb(), rb(), op, ev(1,0,0,0,0,0,0,0,0,0,3'd0));
      access(op, ev(1,1,0,0,0,0,0,0,0,0,3'd1), wf, ok);
      if (!ok) begin
         halted(op, 1'b1, hdwell);
         return;
      end
      push(1'b0, rb(), rb(), op, ev(1,1,0,0,1,0,0,0,0,0,3'd2));
      push(1'b0, rb(), rb(), op, ev(0,0,0,0,0,1,0,0,0,0,3'd3));
      case (op)
         3'd0: halted(op, 1'b0, hdwell);
         3'd1: push(1'b0, rb(), z, op, ev(0,0,0,0,0,z,0,0,0,0,3'd5));
         3'd7: push(1'b0, rb(), rb(), op, ev(0,0,0,0,0,0,1,0,0,0,3'd5));
         3'd6: begin
            access(op, ev(0,0,1,1,0,0,0,0,0,0,3'd6), ws, ok);
            if (!ok) halted(op, 1'b1, hdwell);
         end
         default: begin
            access(op, ev(0,1,0,0,0,0,0,0,0,0,3'd4), wo, ok);
            if (ok) push(1'b0, rb(), rb(), op, ev(0,1,0,0,0,0,0,1,0,0,3'd5));
            else    halted(op, 1'b1, hdwell);
         end
      endcase
   endtask

   task automatic apply(input string name);
      obs_cyc = 0; obs_inc = 0; obs_h = 1'b0; obs_be = 1'b0;
      while (q.size() > 0) begin
         cyc_t c;
         c = q.pop_front();
         rst = c.rst; mem_rdy = c.rdy; zero = c.z; opcode = c.op;
         #1;
         chk(name, obs, c.exp);
         if (!c.rst && !halt) obs_cyc++;
         if (inc_pc) obs_inc++;
         obs_h  = obs_h | halt;
         obs_be = obs_be | bus_err;
         cyc_idx++;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int rand_wait();
      return ($urandom_range(0, 7) == 0) ? LIMIT + int'($urandom_range(0, 1))
                                         : int'($urandom_range(0, LIMIT - 1));
   endfunction

   dir_t dtab[9];

   initial begin
      //           op    z     wf wo ws cyc inc h     be
      dtab[0] = '{3'd0, 1'b0, 0, 0, 0, 4,  1,  1'b1, 1'b0};  // HLT
      dtab[1] = '{3'd2, 1'b0, 0, 0, 0, 6,  1,  1'b0, 1'b0};  // ADD
      dtab[2] = '{3'd1, 1'b1, 0, 0, 0, 5,  2,  1'b0, 1'b0};  // SKZ taken
      dtab[3] = '{3'd1, 1'b0, 0, 0, 0, 5,  1,  1'b0, 1'b0};  // SKZ not taken
      dtab[4] = '{3'd6, 1'b0, 0, 0, 3, 8,  1,  1'b0, 1'b0};  // STO 3 waits
      dtab[5] = '{3'd3, 1'b0, 4, 0, 0, 5,  0,  1'b1, 1'b1};  // fetch timeout
      dtab[6] = '{3'd7, 1'b0, 3, 0, 0, 8,  1,  1'b0, 1'b0};  // ready in limit cycle
      dtab[7] = '{3'd5, 1'b0, 0, 4, 0, 8,  1,  1'b1, 1'b1};  // operand timeout
      dtab[8] = '{3'd4, 1'b0, 1, 2, 0, 9,  1,  1'b0, 1'b0};  // XOR with waits

      rst = 1'b1; mem_rdy = 1'b1; zero = 1'b0; opcode = 3'd0;
      push(1'b1, 1'b1, 1'b0, 3'd0, ev(1,0,0,0,0,0,0,0,0,0,3'd0));
      push(1'b1, 1'b1, 1'b0, 3'd0, ev(1,0,0,0,0,0,0,0,0,0,3'd0));
      apply("reset");

      foreach (dtab[i]) begin
         gen_instr(dtab[i].op, dtab[i].z, dtab[i].wf, dtab[i].wo, dtab[i].ws, 20);
         apply($sformatf("dir%0d", i));
         chk_int($sformatf("dir%0d_cycles", i), obs_cyc, dtab[i].cyc);
         chk_int($sformatf("dir%0d_inc_pc", i), obs_inc, dtab[i].inc);
         chk_int($sformatf("dir%0d_halt", i), int'(obs_h), int'(dtab[i].h));
         chk_int($sformatf("dir%0d_bus_err", i), int'(obs_be), int'(dtab[i].be));
      end

      // reset in the second STORE cycle must kill wr/data_e immediately
      push(1'b0, 1'b1, 1'b0, 3'd6, ev(1,0,0,0,0,0,0,0,0,0,3'd0));
      push(1'b0, 1'b1, 1'b0, 3'd6, ev(1,1,0,0,0,0,0,0,0,0,3'd1));
      push(1'b0, 1'b1, 1'b0, 3'd6, ev(1,1,0,0,1,0,0,0,0,0,3'd2));
      push(1'b0, 1'b1, 1'b0, 3'd6, ev(0,0,0,0,0,1,0,0,0,0,3'd3));
      push(1'b0, 1'b0, 1'b0, 3'd6, ev(0,0,1,1,0,0,0,0,0,0,3'd6));
      push(1'b1, 1'b0, 1'b0, 3'd6, ev(1,0,0,0,0,0,0,0,0,0,3'd0));
      gen_instr(3'd2, 1'b0, 0, 0, 0, 3);
      apply("rst_mid_store");

      for (int n = 0; n < 300; n++) begin
         gen_instr(3'($urandom), rb(), rand_wait(), rand_wait(), rand_wait(), 3);
         apply("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
